// File: rtl/alarm_pkg.sv
// Shared types, widths and BCD conversion helpers for the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    // Operands are widened to the result width before the multiply so the tens digit cannot overflow.
    function automatic logic [HOUR_W-1:0] bcd_to_hour(input logic [1:0] tens, input logic [3:0] units);
        return ({3'b000, tens} * 5'd10) + {1'b0, units};
    endfunction

    function automatic logic [MIN_W-1:0] bcd_to_minute(input logic [2:0] tens, input logic [3:0] units);
        return ({3'b000, tens} * 6'd10) + {2'b00, units};
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: match edge detect, IDLE/RING/SNOOZE FSM and seconds counter.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sec_tick,
    input  logic match,
    input  logic enable,
    input  logic ack,
    input  logic snooze,
    output logic ringing,
    output logic snoozing
);

    localparam int MAX_SEC = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W   = (MAX_SEC > 1) ? $clog2(MAX_SEC + 1) : 1;

    alarm_state_t     state;
    logic [CNT_W-1:0] sec_cnt;
    logic             match_q;
    logic             trigger;

    assign trigger = match && !match_q;

    // match_q comes out of reset high so a setpoint already matching at release does not ring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sec_cnt  <= '0;
            match_q  <= 1'b1;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
        end else begin
            match_q <= match;
            if (!enable) begin
                state    <= ST_IDLE;
                sec_cnt  <= '0;
                ringing  <= 1'b0;
                snoozing <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trigger) begin
                            state   <= ST_RING;
                            sec_cnt <= CNT_W'(RING_SEC);
                            ringing <= 1'b1;
                        end
                    end
                    ST_RING: begin
                        if (ack) begin
                            state   <= ST_IDLE;
                            sec_cnt <= '0;
                            ringing <= 1'b0;
                        end else if (snooze) begin
                            state    <= ST_SNOOZE;
                            sec_cnt  <= CNT_W'(SNOOZE_SEC);
                            ringing  <= 1'b0;
                            snoozing <= 1'b1;
                        end else if (sec_tick) begin
                            if (sec_cnt <= CNT_W'(1)) begin
                                state   <= ST_IDLE;
                                sec_cnt <= '0;
                                ringing <= 1'b0;
                            end else begin
                                sec_cnt <= sec_cnt - CNT_W'(1);
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        if (ack) begin
                            state    <= ST_IDLE;
                            sec_cnt  <= '0;
                            snoozing <= 1'b0;
                        end else if (trigger || (sec_tick && sec_cnt <= CNT_W'(1))) begin
                            state    <= ST_RING;
                            sec_cnt  <= CNT_W'(RING_SEC);
                            ringing  <= 1'b1;
                            snoozing <= 1'b0;
                        end else if (sec_tick) begin
                            sec_cnt <= sec_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        sec_cnt  <= '0;
                        ringing  <= 1'b0;
                        snoozing <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Multi-channel alarm controller: time conversion, per-channel FSMs, LED blink and optional chime.
// Define HOURLY_CHIME_EN to build the hourly chime; otherwise chime is tied low.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int BLINK_HZ   = 2,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int CHIME_SEC  = 2
) (
    input  logic                         CLK_100M,
    input  logic                         RST_N,
    input  logic [1:0]                   hour_high,
    input  logic [3:0]                   hour_low,
    input  logic [2:0]                   minute_high,
    input  logic [3:0]                   minute_low,
    input  logic                         sec_tick,
    input  logic [HOUR_W*NUM_ALARMS-1:0] alarm_hour,
    input  logic [MIN_W*NUM_ALARMS-1:0]  alarm_min,
    input  logic [NUM_ALARMS-1:0]        alarm_en,
    input  logic                         ack,
    input  logic                         snooze,
    output logic [NUM_ALARMS-1:0]        ringing,
    output logic [NUM_ALARMS-1:0]        snoozing,
    output logic                         blink,
    output logic                         chime
);

    localparam int HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
    localparam int PH_W        = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [HOUR_W-1:0]     hour;
    logic [MIN_W-1:0]      minute;
    logic [NUM_ALARMS-1:0] match;
    logic                  any_ringing;
    logic                  ringing_d;
    logic [PH_W-1:0]       phase;

    assign hour        = bcd_to_hour(hour_high, hour_low);
    assign minute      = bcd_to_minute(minute_high, minute_low);
    assign any_ringing = |ringing;

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        assign match[i] = alarm_en[i]
                       && (hour == alarm_hour[HOUR_W*i +: HOUR_W])
                       && (minute == alarm_min[MIN_W*i +: MIN_W]);

        alarm_channel #(
            .RING_SEC   (RING_SEC),
            .SNOOZE_SEC (SNOOZE_SEC)
        ) u_chan (
            .clk      (CLK_100M),
            .rst_n    (RST_N),
            .sec_tick (sec_tick),
            .match    (match[i]),
            .enable   (alarm_en[i]),
            .ack      (ack),
            .snooze   (snooze),
            .ringing  (ringing[i]),
            .snoozing (snoozing[i])
        );
    end

    // Blink starts lit on the first ringing cycle, then toggles every HALF_PERIOD clocks.
    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            blink     <= 1'b0;
            ringing_d <= 1'b0;
            phase     <= '0;
        end else begin
            ringing_d <= any_ringing;
            if (!any_ringing) begin
                blink <= 1'b0;
                phase <= '0;
            end else if (!ringing_d) begin
                blink <= 1'b1;
                phase <= '0;
            end else if (phase == PH_W'(HALF_PERIOD - 1)) begin
                blink <= ~blink;
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

`ifdef HOURLY_CHIME_EN
    localparam int CH_W = (CHIME_SEC > 1) ? $clog2(CHIME_SEC + 1) : 1;

    logic [MIN_W-1:0] minute_q;
    logic [MIN_W-1:0] minute_qq;
    logic [CH_W-1:0]  chime_cnt;

    // A ringing alarm cancels any chime in progress.
    always_ff @(posedge CLK_100M or negedge RST_N) begin
        if (!RST_N) begin
            minute_q  <= '0;
            minute_qq <= '0;
            chime_cnt <= '0;
            chime     <= 1'b0;
        end else begin
            minute_q  <= minute;
            minute_qq <= minute_q;
            if (any_ringing) begin
                chime_cnt <= '0;
                chime     <= 1'b0;
            end else if (minute_q == '0 && minute_qq != '0) begin
                chime_cnt <= CH_W'(CHIME_SEC);
                chime     <= 1'b1;
            end else if (sec_tick && chime_cnt != '0) begin
                chime_cnt <= chime_cnt - CH_W'(1);
                if (chime_cnt == CH_W'(1)) begin
                    chime <= 1'b0;
                end
            end
        end
    end
`else
    assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed testbench for alarm_ring_ctrl with small timing parameters.
module tb_alarm_ring_ctrl;

    localparam int NA = 2;

    logic          CLK_100M = 1'b0;
    logic          RST_N    = 1'b0;
    logic [1:0]    hour_high   = '0;
    logic [3:0]    hour_low    = '0;
    logic [2:0]    minute_high = '0;
    logic [3:0]    minute_low  = '0;
    logic          sec_tick = 1'b0;
    logic [5*NA-1:0] alarm_hour = '0;
    logic [6*NA-1:0] alarm_min  = '0;
    logic [NA-1:0] alarm_en = '0;
    logic          ack    = 1'b0;
    logic          snooze = 1'b0;
    logic [NA-1:0] ringing;
    logic [NA-1:0] snoozing;
    logic          blink;
    logic          chime;

    int vectors     = 0;
    int miscompares = 0;

`ifdef HOURLY_CHIME_EN
    localparam logic CHIME_ON = 1'b1;
`else
    localparam logic CHIME_ON = 1'b0;
`endif

    alarm_ring_ctrl #(
        .NUM_ALARMS (NA),
        .CLK_HZ     (100),
        .BLINK_HZ   (10),
        .RING_SEC   (3),
        .SNOOZE_SEC (4),
        .CHIME_SEC  (2)
    ) dut (
        .CLK_100M    (CLK_100M),
        .RST_N       (RST_N),
        .hour_high   (hour_high),
        .hour_low    (hour_low),
        .minute_high (minute_high),
        .minute_low  (minute_low),
        .sec_tick    (sec_tick),
        .alarm_hour  (alarm_hour),
        .alarm_min   (alarm_min),
        .alarm_en    (alarm_en),
        .ack         (ack),
        .snooze      (snooze),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .blink       (blink),
        .chime       (chime)
    );

    always #5 CLK_100M = ~CLK_100M;

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK_100M);
    endtask

    task automatic applyStimulus(input int hh, input int mm);
        hour_high   = 2'(hh / 10);
        hour_low    = 4'(hh % 10);
        minute_high = 3'(mm / 10);
        minute_low  = 4'(mm % 10);
    endtask

    task automatic pulseInputs(input logic a, input logic s, input logic t);
        ack      = a;
        snooze   = s;
        sec_tick = t;
        step(1);
        ack      = 1'b0;
        snooze   = 1'b0;
        sec_tick = 1'b0;
    endtask

    initial begin
        step(2);
        checkOutput("reset_ringing",  8'(ringing),  8'h00);
        checkOutput("reset_snoozing", 8'(snoozing), 8'h00);
        checkOutput("reset_blink",    8'(blink),    8'h00);
        checkOutput("reset_chime",    8'(chime),    8'h00);

        // ch0 at 07:30, ring and watch the blink pattern
        alarm_hour = {5'd12, 5'd7};
        alarm_min  = {6'd0, 6'd30};
        alarm_en   = 2'b01;
        applyStimulus(7, 29);
        RST_N = 1'b1;
        step(3);
        checkOutput("no_ring_0729", 8'(ringing), 8'h00);
        applyStimulus(7, 30);
        step(1);
        checkOutput("ring_latency", 8'(ringing), 8'h01);
        checkOutput("blink_lag",    8'(blink),   8'h00);
        step(1);
        checkOutput("blink_first",  8'(blink),   8'h01);
        step(4);
        checkOutput("blink_hold",   8'(blink),   8'h01);
        step(1);
        checkOutput("blink_toggle0", 8'(blink),  8'h00);
        step(5);
        checkOutput("blink_toggle1", 8'(blink),  8'h01);

        // ring timeout after three seconds, no retrigger in the same minute
        pulseInputs(1'b0, 1'b0, 1'b1);
        pulseInputs(1'b0, 1'b0, 1'b1);
        checkOutput("ring_2ticks", 8'(ringing), 8'h01);
        pulseInputs(1'b0, 1'b0, 1'b1);
        checkOutput("ring_timeout", 8'(ringing), 8'h00);
        step(1);
        checkOutput("blink_off_timeout", 8'(blink), 8'h00);
        step(5);
        checkOutput("no_retrigger", 8'(ringing), 8'h00);

        // snooze, snooze ignored while snoozing, re-ring after four seconds, ack
        applyStimulus(7, 31);
        step(2);
        applyStimulus(7, 30);
        step(1);
        checkOutput("ring_again", 8'(ringing), 8'h01);
        pulseInputs(1'b0, 1'b1, 1'b0);
        checkOutput("snooze_flag", 8'(snoozing), 8'h01);
        checkOutput("snooze_not_ring", 8'(ringing), 8'h00);
        step(1);
        checkOutput("blink_snooze", 8'(blink), 8'h00);
        pulseInputs(1'b0, 1'b0, 1'b1);
        pulseInputs(1'b0, 1'b1, 1'b0);
        checkOutput("snooze_ignored", 8'(snoozing), 8'h01);
        pulseInputs(1'b0, 1'b0, 1'b1);
        pulseInputs(1'b0, 1'b0, 1'b1);
        checkOutput("snooze_3ticks", 8'(snoozing), 8'h01);
        pulseInputs(1'b0, 1'b0, 1'b1);
        checkOutput("snooze_expire_ring", 8'(ringing), 8'h01);
        checkOutput("snooze_expire_flag", 8'(snoozing), 8'h00);
        pulseInputs(1'b1, 1'b0, 1'b0);
        checkOutput("ack_ringing",  8'(ringing),  8'h00);
        checkOutput("ack_snoozing", 8'(snoozing), 8'h00);

        // both channels at 12:00, ack beats snooze
        alarm_hour = {5'd12, 5'd12};
        alarm_min  = {6'd0, 6'd0};
        alarm_en   = 2'b11;
        applyStimulus(11, 59);
        step(2);
        applyStimulus(12, 0);
        step(1);
        checkOutput("dual_ring", 8'(ringing), 8'h03);
        step(2);
        checkOutput("dual_blink", 8'(blink), 8'h01);
        pulseInputs(1'b1, 1'b1, 1'b0);
        checkOutput("ack_wins_ring",   8'(ringing),  8'h00);
        checkOutput("ack_wins_snooze", 8'(snoozing), 8'h00);

        // disable one channel mid-ring, then reset mid-snooze
        applyStimulus(11, 58);
        step(2);
        applyStimulus(12, 0);
        step(1);
        checkOutput("dual_ring2", 8'(ringing), 8'h03);
        alarm_en = 2'b10;
        step(1);
        checkOutput("disable_ch0", 8'(ringing), 8'h02);
        pulseInputs(1'b0, 1'b1, 1'b0);
        checkOutput("ch1_snooze", 8'(snoozing), 8'h02);
        pulseInputs(1'b0, 1'b0, 1'b1);
        RST_N = 1'b0;
        #1;
        checkOutput("async_rst_ringing",  8'(ringing),  8'h00);
        checkOutput("async_rst_snoozing", 8'(snoozing), 8'h00);
        checkOutput("async_rst_blink",    8'(blink),    8'h00);
        step(2);
        RST_N = 1'b1;
        step(5);
        checkOutput("no_ring_after_rst", 8'(ringing),  8'h00);
        checkOutput("no_snz_after_rst",  8'(snoozing), 8'h00);

        // hourly chime on 08:59 -> 09:00
        alarm_en = 2'b00;
        applyStimulus(8, 59);
        step(3);
        checkOutput("chime_idle", 8'(chime), 8'h00);
        applyStimulus(9, 0);
        step(2);
        checkOutput("chime_start", 8'(chime), 8'(CHIME_ON));
        pulseInputs(1'b0, 1'b0, 1'b1);
        checkOutput("chime_1tick", 8'(chime), 8'(CHIME_ON));
        pulseInputs(1'b0, 1'b0, 1'b1);
        checkOutput("chime_end", 8'(chime), 8'h00);
        checkOutput("chime_no_ring", 8'(ringing), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
